// File: rtl/uart_pkg.sv
// Shared types and constants for the custom UART receive path.
// Frame format is 8N1: idle high, start 0, eight data bits LSB first, stop 1.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Data arrives LSB first, so each new bit enters at the MSB end and
    // the byte is complete in place after the eighth shift.
    function automatic logic [UART_DATA_BITS-1:0] shift_in_lsb_first(
        input logic [UART_DATA_BITS-1:0] cur,
        input logic                      bit_in
    );
        return {bit_in, cur[UART_DATA_BITS-1:1]};
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Single-bit multi-flop synchronizer with a synchronous reset value.
// Used on the asynchronous rx line and on the transmitter's ena/send inputs.
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, finds the start bit, samples every
// bit at its centre and hands completed bytes to a valid/ack holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       bussy
);

    localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_state_e                state_q,     state_d;
    logic [CNT_W-1:0]           clk_cnt_q,   clk_cnt_d;
    logic [2:0]                 bit_cnt_q,   bit_cnt_d;
    logic [UART_DATA_BITS-1:0]  shift_q,     shift_d;
    logic [UART_DATA_BITS-1:0]  data_q,      data_d;
    logic                       valid_q,     valid_d;
    logic                       overrun_q,   overrun_d;
    logic                       frame_err_q, frame_err_d;
    logic                       bussy_q,     bussy_d;
    logic                       stop_good;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame FSM. The stop bit is sampled at its centre and IDLE is re-entered
    // there, leaving half a bit of margin to catch a back-to-back start bit.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        stop_good   = 1'b0;

        if (!ena) begin
            state_d   = IDLE;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    clk_cnt_d = '0;
                    if (rx_s != UART_IDLE_LEVEL) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_d = '0;
                        bit_cnt_d = '0;
                        state_d   = (rx_s == UART_IDLE_LEVEL) ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_d = '0;
                        shift_d   = shift_in_lsb_first(shift_q, rx_s);
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_d = '0;
                        state_d   = IDLE;
                        if (rx_s == UART_IDLE_LEVEL) begin
                            stop_good = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                end
            endcase
        end
    end

    // Holding register handshake: valid stays high until rx_ack is seen with
    // valid set. A byte completing while valid is still set and not acked in
    // that same cycle is dropped and overrun latches; rx_ack clears both.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (stop_good) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        bussy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            bussy_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            bussy_q     <= bussy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign bussy     = bussy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, corner-case
// sequences and a randomized line checked against a cycle-level model.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int H    = CPB / 2;
    localparam int LAT  = SYNC + H + 9 * CPB;
    localparam int FRAME_LEN = 10 * CPB;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       ena    = 1'b1;
    logic       rx     = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       bussy;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .bussy     (bussy)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // bookkeeping
    int n_cmp  = 0;
    int n_fail = 0;

    logic prev_valid = 1'b0;
    int   rise_cyc   = -1;
    int   fe_cnt     = 0;
    int   fe_cyc     = -1;
    int   busy_cnt   = 0;
    int   drive_cyc  = 0;

    // scoreboard / reference model state
    typedef struct {
        int   cyc;
        logic good;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] exp_q[$];
    logic       model_on = 1'b0;
    logic [7:0] m_data   = 8'h00;
    logic       m_valid  = 1'b0;
    logic       m_ov     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        ev_t        e;
        logic [7:0] b;
        logic       exp_fe;
        logic       ack;
        exp_fe = 1'b0;
        ack    = rx_ack;
        if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
            e = ev_q.pop_front();
            b = exp_q.pop_front();
            if (e.good) begin
                if (!m_valid || ack) begin
                    m_data  = b;
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else begin
                exp_fe = 1'b1;
                if (ack) begin
                    m_valid = 1'b0;
                    m_ov    = 1'b0;
                end
            end
        end else if (ack) begin
            m_valid = 1'b0;
            m_ov    = 1'b0;
        end
        chk("model {data,valid,overrun,frame_err}",
            {data, valid, overrun, frame_err}, {m_data, m_valid, m_ov, exp_fe});
    endtask

    task automatic mon_sample();
        if (valid && !prev_valid) rise_cyc = cyc;
        prev_valid = valid;
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (bussy) busy_cnt++;
        if (model_on) model_check();
    endtask

    task automatic clear_stats();
        prev_valid = valid;
        rise_cyc   = -1;
        fe_cnt     = 0;
        fe_cyc     = -1;
        busy_cnt   = 0;
    endtask

    // driver tasks
    task automatic step(input logic r, input logic a);
        @(negedge clk);
        mon_sample();
        rx        = r;
        rx_ack    = a;
        drive_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_j,
                              input int cut, output int t0);
        t0 = -1;
        for (int j = 0; j < cut; j++) begin
            int   k;
            logic r;
            k = j / CPB;
            if (k == 0)      r = 1'b0;
            else if (k <= 8) r = b[k-1];
            else             r = stop;
            step(r, (j == ack_j));
            if (j == 0) t0 = drive_cyc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        ena    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset data", data, 8'h00);
        chk("reset valid", valid, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset overrun", overrun, 1'b0);
        chk("reset bussy", bussy, 1'b0);
        rst = 1'b0;
        clear_stats();
    endtask

    // directed frame table
    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       ack;
        logic       rise;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_fe;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int         t0, t1, t2;
        logic       line_q[$];
        int         start_q[$];
        logic       good_q[$];
        int         fi;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            send_frame(vecs[i].b, vecs[i].stop, -1, FRAME_LEN, t0);
            chk("vec valid rise cycle", rise_cyc, vecs[i].rise ? (t0 + LAT) : -1);
            chk("vec frame_err pulses", fe_cnt, vecs[i].e_fe ? 1 : 0);
            if (vecs[i].e_fe) chk("vec frame_err cycle", fe_cyc, t0 + LAT);
            chk("vec overrun", overrun, 1'b0);
            if (vecs[i].ack) begin
                step(1'b1, 1'b1);
                step(1'b1, 1'b0);
            end
            chk("vec data", data, vecs[i].e_data);
            chk("vec valid", valid, vecs[i].e_valid);
        end

        // short low glitch is rejected after half a bit
        do_reset();
        repeat (4) step(1'b0, 1'b0);
        idle(30);
        chk("glitch bussy cycles", busy_cnt, H);
        chk("glitch valid", valid, 1'b0);
        chk("glitch frame_err pulses", fe_cnt, 0);
        chk("glitch overrun", overrun, 1'b0);

        // back-to-back frames without ack
        do_reset();
        send_frame(8'h11, 1'b1, -1, FRAME_LEN, t0);
        send_frame(8'h22, 1'b1, -1, FRAME_LEN, t1);
        idle(4);
        chk("b2b first rise", rise_cyc, t0 + LAT);
        chk("b2b data", data, 8'h11);
        chk("b2b valid", valid, 1'b1);
        chk("b2b overrun", overrun, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("b2b ack valid", valid, 1'b0);
        chk("b2b ack overrun", overrun, 1'b0);

        // ack on the exact delivery cycle of the next byte
        do_reset();
        send_frame(8'h11, 1'b1, -1, FRAME_LEN, t0);
        idle(5);
        send_frame(8'h77, 1'b1, LAT, FRAME_LEN, t1);
        idle(2);
        chk("ack-on-deliver data", data, 8'h77);
        chk("ack-on-deliver valid", valid, 1'b1);
        chk("ack-on-deliver overrun", overrun, 1'b0);
        chk("ack-on-deliver no valid gap", rise_cyc, t0 + LAT);

        // rst in the middle of data bit 4
        do_reset();
        send_frame(8'h33, 1'b1, -1, FRAME_LEN, t0);
        idle(2);
        chk("pre-rst data", data, 8'h33);
        send_frame(8'hFF, 1'b1, -1, 5 * CPB + 8, t1);
        do_reset();
        idle(200);
        chk("post-rst valid", valid, 1'b0);
        chk("post-rst frame_err pulses", fe_cnt, 0);
        send_frame(8'h5A, 1'b1, -1, FRAME_LEN, t2);
        idle(2);
        chk("post-rst rise", rise_cyc, t2 + LAT);
        chk("post-rst data", data, 8'h5A);
        chk("post-rst valid 5A", valid, 1'b1);

        // ena dropped in the middle of data bit 4
        do_reset();
        send_frame(8'h33, 1'b1, -1, FRAME_LEN, t0);
        idle(2);
        send_frame(8'hFF, 1'b1, -1, 5 * CPB + 8, t1);
        ena = 1'b0;
        step(1'b1, 1'b0);
        chk("ena-off bussy", bussy, 1'b0);
        chk("ena-off data kept", data, 8'h33);
        chk("ena-off valid kept", valid, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("ena-off ack valid", valid, 1'b0);
        ena = 1'b1;
        clear_stats();
        idle(200);
        chk("ena-on no delivery", rise_cyc, -1);
        chk("ena-on data kept", data, 8'h33);
        chk("ena-on frame_err pulses", fe_cnt, 0);
        chk("ena-on overrun", overrun, 1'b0);
        send_frame(8'h5A, 1'b1, -1, FRAME_LEN, t2);
        idle(2);
        chk("ena-on rise", rise_cyc, t2 + LAT);
        chk("ena-on data", data, 8'h5A);
        chk("ena-on valid", valid, 1'b1);

        // randomized line against the reference model
        do_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ov    = 1'b0;
        for (int f = 0; f < 25; f++) begin
            logic [7:0] b;
            logic       good;
            int         gap;
            good = ($urandom_range(0, 4) != 0);
            b    = 8'($urandom);
            gap  = good ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 10));
            start_q.push_back(line_q.size());
            good_q.push_back(good);
            exp_q.push_back(b);
            for (int j = 0; j < FRAME_LEN; j++) begin
                int k;
                k = j / CPB;
                if (k == 0)      line_q.push_back(1'b0);
                else if (k <= 8) line_q.push_back(b[k-1]);
                else             line_q.push_back(good);
            end
            for (int g = 0; g < gap; g++) line_q.push_back(1'b1);
        end
        for (int g = 0; g < 30; g++) line_q.push_back(1'b1);

        model_on = 1'b1;
        fi = 0;
        for (int j = 0; j < line_q.size(); j++) begin
            step(line_q[j], ($urandom_range(0, 15) == 0));
            if (fi < start_q.size() && start_q[fi] == j) begin
                ev_q.push_back('{drive_cyc + LAT, good_q[fi]});
                fi++;
            end
        end
        model_on = 1'b0;
        rx_ack   = 1'b0;
        chk("random events left", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage of the custom UART, the downstream counterpart of the FSM transmitter.
- Consumes the 8N1 line the transmitter drives: idle high, start bit 0, 8 data bits LSB-first, stop bit 1.
- Oversamples the line with a per-bit clock counter, samples each bit at its centre and presents the byte on a valid/ack holding register.
- Flags framing errors and overruns for the consuming logic.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.
- SYNC_STAGES, 2, flip-flops in the rx input synchronizer; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  receiver enable; low aborts any frame and holds the FSM in IDLE.
- rx  in  1  asynchronous serial line.
- rx_ack  in  1  consumer has taken data; clears valid and overrun.
- data  out  8  last good received byte.
- valid  out  1  data holds an unconsumed byte.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  sticky: a good byte was dropped because valid was still set.
- bussy  out  1  high while a frame is in progress.

Behaviour:
- Reset, synchronous on clk while rst=1:
  - data=0x00, valid=0, frame_err=0, overrun=0, bussy=0.
  - Synchronizer flops reset to 1 (line idle).
  - FSM=IDLE; clk_cnt=0, bit_cnt=0, shift=0.
  - rst asserted mid-frame aborts the frame; nothing is delivered.
- Synchronizer: rx passes through SYNC_STAGES flops; rx_s is the last stage. All decisions below use rx_s.
- Counters:
  - clk_cnt is clog2(CLKS_PER_BIT) bits and is cleared on every state change.
  - bit_cnt is 3 bits.
  - H = CLKS_PER_BIT/2.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s=0 -> START, clk_cnt=0.
  - START: counts. At clk_cnt==H-1: if rx_s=0 -> DATA, clk_cnt=0, bit_cnt=0; else -> IDLE (glitch rejected, no flag).
  - DATA: at clk_cnt==CLKS_PER_BIT-1: shift <= {rx_s, shift[7:1]}, clk_cnt=0, bit_cnt+1. After the 8th sample (bit_cnt was 7) -> STOP.
  - STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s, then -> IDLE.
    - rx_s=1: deliver.
    - rx_s=0: frame_err=1 for exactly one cycle; byte discarded.
  - IDLE is re-entered at the stop-bit centre, so a start bit immediately following is detected.
- ena=0 (checked before the FSM logic): FSM -> IDLE, counters cleared, no delivery. data, valid and overrun are retained, and rx_ack is still honoured.
- Deliver, same edge as the stop sample:
  - If valid=0 or rx_ack=1 that cycle: data<=shift, valid<=1, overrun unchanged.
  - Else: data unchanged, valid stays 1, overrun<=1.
- rx_ack with no delivery that cycle: valid<=0, overrun<=0. rx_ack while valid=0 has no effect.
- bussy = (state != IDLE), registered with the state.
- Latency: let t0 be the first clk edge at which rx is low at the input.
  - FSM enters START at t0+SYNC_STAGES.
  - valid and data update at t0 + SYNC_STAGES + H + 9*CLKS_PER_BIT.
  - With defaults this is t0+154.
- Back-to-back frames: sustained at line rate with no gap beyond the stop bit.

Decomposition:
- Package uart_pkg:
  - state encoding constants IDLE/START/DATA/STOP;
  - UART_DATA_BITS=8;
  - UART_IDLE_LEVEL=1'b1.
- Sub-module uart_sync: SYNC_STAGES-deep single-bit synchronizer with synchronous reset to a parameterised value (1 here). It is reused by the Tx ena/send path.

Test Plan:
- Frame 0xA5, defaults, ack 5 cycles after valid -> valid rises at t0+154, data=0xA5, frame_err never 1, overrun 0, valid falls the cycle after ack.
- rx low for 4 cycles then high -> FSM returns to IDLE; valid, frame_err and overrun stay 0; bussy high for exactly H cycles.
- Frame 0x3C with stop bit driven 0 -> frame_err high exactly one cycle at t0+154, valid stays 0, data unchanged (0x00).
- Back-to-back frames 0x11 then 0x22, no ack -> data=0x11, valid=1, overrun=1 after the second stop. One rx_ack -> valid=0, overrun=0.
- Frame 0x77 with rx_ack pulsed on the exact delivery cycle of a pending 0x11 -> data=0x77, valid=1, overrun=0.
- rst pulsed during data bit 4 of 0xFF, then frame 0x5A -> all outputs at reset values after the rst edge, no byte from the aborted frame, then data=0x5A, valid=1. Repeat with ena=0 mid-frame: same result, and previously held data is retained.
